wb_arbiter: RTL

Writeback arbiter sitting directly downstream of the execution units (ALU, LSU, FPU, ...). Each cycle it scans the `resp` ports of all units, claims up to `wwd` valid, non-squashed results, and presents them registered on the writeback bus that feeds the register file and ROB completion logic. Squashed results (younger than an active redirect) are claimed and discarded without consuming a writeback slot. The registered output stage is itself filtered against redirects.

---
 rtl/wb_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter downstream of the execution units.
//
// Each cycle scans every unit's response slots, claims up to wwd valid,
// non-squashed results and registers them onto the writeback bus. Squashed
// results are claimed and dropped without consuming a writeback lane.
//
// Parameters
//   nfu  : number of functional units
//   ewd  : response slots per unit
//   wwd  : writeback lanes per cycle
//   opsz : op ID space; age arithmetic on $clog2(opsz) bits
//
// Ports
//   clk      : clock
//   rst      : synchronous active-high reset
//   redir    : redirect bundle, active when redir.opid[15]
//   fu_resp  : unit results, slot valid when opid[15]
//   fu_claim : combinational claim per unit slot
//   wb       : registered writeback lanes, valid when opid[15]
//
// Build option
//   WBARB_ROUNDROBIN_EN : scan starts at a rotating unit pointer (fair);
//                         otherwise unit 0 always has highest priority.

package wb_arbiter_pkg;

   typedef struct packed {
      logic [15:0] opid;   // [15] valid, low bits carry the op ID
      logic [6:0]  prda;
      logic        prdv;
      logic [31:0] data;
   } exe_bundle_t;

   typedef struct packed {
      logic [15:0] opid;   // [15] redirect active
      logic [15:0] topid;  // oldest op in flight, reference for age compare
   } red_bundle_t;

endpackage

module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned nfu  = 4,
   parameter int unsigned ewd  = 4,
   parameter int unsigned wwd  = 4,
   parameter int unsigned opsz = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  red_bundle_t                  redir,
   input  exe_bundle_t [nfu-1:0][ewd-1:0] fu_resp,
   output logic        [nfu-1:0][ewd-1:0] fu_claim,
   output exe_bundle_t [wwd-1:0]          wb
);

   localparam int unsigned OW = (opsz > 1) ? $clog2(opsz) : 1;
   localparam int unsigned UW = (nfu > 1) ? $clog2(nfu) : 1;
   localparam int unsigned LW = (wwd > 1) ? $clog2(wwd) : 1;
   localparam logic [UW:0] NFU_W = (UW+1)'(nfu);
   localparam logic [LW:0] WWD_W = (LW+1)'(wwd);

   // Op ID bits above the age field never take part in the compare.
   logic unused_redir_hi;
   assign unused_redir_hi = ^{redir.opid[14:OW], redir.topid[15:OW]};

   // Younger than the redirect point, both ages measured from topid modulo opsz.
   // "age_x >= age_r + 1" is evaluated as a strict compare so the +1 cannot wrap.
   function automatic logic is_squashed(input logic [15:0] x, input red_bundle_t r);
      logic [OW-1:0] age_x;
      logic [OW-1:0] age_r;
      age_x = x[OW-1:0] - r.topid[OW-1:0];
      age_r = r.opid[OW-1:0] - r.topid[OW-1:0];
      return r.opid[15] & x[15] & (age_x > age_r);
   endfunction

   logic [UW-1:0]                 scan_start;
   logic [UW:0]                   unit_sum;
   logic [UW-1:0]                 unit_idx;
   logic                          unit_blocked;
   logic [LW:0]                   n_sel;
   logic [nfu-1:0][ewd-1:0]       claim_raw;
   exe_bundle_t [wwd-1:0]         sel;

`ifdef WBARB_ROUNDROBIN_EN
   logic [UW-1:0] rr_ptr;
   logic [UW-1:0] rr_next;
   logic [UW-1:0] last_unit;
   logic [UW:0]   last_sum;
   logic          any_placed;

   assign scan_start = rr_ptr;
`else
   assign scan_start = '0;
`endif

   always_comb begin
      claim_raw    = '0;
      sel          = '0;
      n_sel        = '0;
      unit_sum     = '0;
      unit_idx     = '0;
      unit_blocked = 1'b0;
`ifdef WBARB_ROUNDROBIN_EN
      last_unit    = scan_start;
      any_placed   = 1'b0;
      last_sum     = '0;
      rr_next      = rr_ptr;
`endif
      for (int unsigned k = 0; k < nfu; k++) begin
         unit_sum = {1'b0, scan_start} + (UW+1)'(k);
         if (unit_sum >= NFU_W)
            unit_sum = unit_sum - NFU_W;
         unit_idx = unit_sum[UW-1:0];
         // Once a live result of this unit is refused, nothing younger in the
         // same unit may be claimed, squashed or not, to keep claims hole-free.
         unit_blocked = 1'b0;
         for (int unsigned j = 0; j < ewd; j++) begin
            if (fu_resp[unit_idx][j].opid[15] && !unit_blocked) begin
               if (is_squashed(fu_resp[unit_idx][j].opid, redir)) begin
                  claim_raw[unit_idx][j] = 1'b1;
               end else if (n_sel < WWD_W) begin
                  claim_raw[unit_idx][j]   = 1'b1;
                  sel[n_sel[LW-1:0]]       = fu_resp[unit_idx][j];
                  n_sel                    = n_sel + (LW+1)'(1);
`ifdef WBARB_ROUNDROBIN_EN
                  last_unit                = unit_idx;
                  any_placed               = 1'b1;
`endif
               end else begin
                  unit_blocked = 1'b1;
               end
            end
         end
      end
`ifdef WBARB_ROUNDROBIN_EN
      last_sum = {1'b0, last_unit} + (UW+1)'(1);
      if (last_sum >= NFU_W)
         last_sum = '0;
      if (any_placed)
         rr_next = last_sum[UW-1:0];
`endif
   end

   assign fu_claim = rst ? '0 : claim_raw;

`ifdef WBARB_ROUNDROBIN_EN
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else
         rr_ptr <= rr_next;
   end
`endif

   // Lanes are re-checked against the redirect seen this cycle as they load.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb <= '0;
      end else begin
         for (int unsigned l = 0; l < wwd; l++) begin
            wb[l] <= sel[l];
            if (is_squashed(sel[l].opid, redir))
               wb[l].opid <= '0;
         end
      end
   end

endmodule
